// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 note-key decoder:
// frame FSM states, scan code set 2 values and the ASCII note-key codes.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } frame_state_e;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;

    localparam logic [7:0] SC_Q = 8'h15;
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_R = 8'h2D;
    localparam logic [7:0] SC_T = 8'h2C;
    localparam logic [7:0] SC_Y = 8'h35;
    localparam logic [7:0] SC_U = 8'h3C;
    localparam logic [7:0] SC_I = 8'h43;
    localparam logic [7:0] SC_O = 8'h44;
    localparam logic [7:0] SC_P = 8'h4D;
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_G = 8'h34;
    localparam logic [7:0] SC_H = 8'h33;
    localparam logic [7:0] SC_J = 8'h3B;
    localparam logic [7:0] SC_K = 8'h42;
    localparam logic [7:0] SC_L = 8'h4B;

    localparam logic [6:0] ASCII_Q = 7'd81;
    localparam logic [6:0] ASCII_W = 7'd87;
    localparam logic [6:0] ASCII_E = 7'd69;
    localparam logic [6:0] ASCII_R = 7'd82;
    localparam logic [6:0] ASCII_T = 7'd84;
    localparam logic [6:0] ASCII_Y = 7'd89;
    localparam logic [6:0] ASCII_U = 7'd85;
    localparam logic [6:0] ASCII_I = 7'd73;
    localparam logic [6:0] ASCII_O = 7'd79;
    localparam logic [6:0] ASCII_P = 7'd80;
    localparam logic [6:0] ASCII_A = 7'd65;
    localparam logic [6:0] ASCII_S = 7'd83;
    localparam logic [6:0] ASCII_D = 7'd68;
    localparam logic [6:0] ASCII_F = 7'd70;
    localparam logic [6:0] ASCII_G = 7'd71;
    localparam logic [6:0] ASCII_H = 7'd72;
    localparam logic [6:0] ASCII_J = 7'd74;
    localparam logic [6:0] ASCII_K = 7'd75;
    localparam logic [6:0] ASCII_L = 7'd76;

    localparam logic [6:0] UNMAPPED = 7'h7F;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, falling-edge detect,
// 11-bit frame FSM with odd-parity/stop checks and an inactivity timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clock,
    input  logic       i_resetn,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_byte,
    output logic       o_byte_strobe,
    output logic       o_frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic r_clk_meta, r_clk_sync, r_clk_prev;
    logic r_dat_meta, r_dat_sync;
    logic w_fall;

    frame_state_e r_state, w_state_nxt;
    logic [2:0]    r_cnt, w_cnt_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_par, w_par_nxt;
    logic [TW-1:0] r_tmo;
    logic          w_timeout;
    logic          w_accept, w_err;
    logic [7:0]    r_byte;
    logic          r_strobe, r_err;

    // Sync flops reset high (PS/2 idle level) so release never looks like a fall.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= i_ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= i_ps2_dat;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_sync;
    assign w_timeout = (r_state != StIdle) && (r_tmo == TW'(TIMEOUT_CYCLES));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_accept    = 1'b0;
        w_err       = 1'b0;
        if (w_timeout) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = 3'd0;
            w_err       = 1'b1;
        end else if (w_fall) begin
            unique case (r_state)
                StIdle: begin
                    if (!r_dat_sync) begin
                        w_state_nxt = StData;
                        w_cnt_nxt   = 3'd0;
                    end
                end
                StData: begin
                    w_shift_nxt = {r_dat_sync, r_shift[7:1]};
                    w_cnt_nxt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_state_nxt = StParity;
                    end
                end
                StParity: begin
                    w_par_nxt   = r_dat_sync;
                    w_state_nxt = StStop;
                end
                StStop: begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = 3'd0;
                    if ((^{r_shift, r_par}) && r_dat_sync) begin
                        w_accept = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state  <= StIdle;
            r_cnt    <= 3'd0;
            r_shift  <= 8'h00;
            r_par    <= 1'b0;
            r_tmo    <= '0;
            r_byte   <= 8'h00;
            r_strobe <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shift  <= w_shift_nxt;
            r_par    <= w_par_nxt;
            r_strobe <= w_accept;
            r_err    <= w_err;
            if (w_accept) begin
                r_byte <= r_shift;
            end
            if (r_state == StIdle || w_fall) begin
                r_tmo <= '0;
            end else if (r_tmo != TW'(TIMEOUT_CYCLES)) begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end

    assign o_byte        = r_byte;
    assign o_byte_strobe = r_strobe;
    assign o_frame_err   = r_err;

endmodule

// File: rtl/ps2_note_key_decoder.sv
// PS/2 note-key decoder: turns scan code set 2 make/break traffic into a
// held ASCII note value with a one-cycle press pulse and a key-down level.
module ps2_note_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [6:0] ascii_val,
    output logic       key_valid,
    output logic       key_held,
    output logic       frame_err
);

    logic [7:0] w_byte;
    logic       w_strobe;
    logic       w_rx_err;
    logic [6:0] w_map;

    logic [6:0] r_ascii;
    logic       r_valid, r_held, r_ferr;
    logic       r_ext, r_brk;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .i_clock      (clock),
        .i_resetn     (resetn),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_dat    (ps2_dat),
        .o_byte       (w_byte),
        .o_byte_strobe(w_strobe),
        .o_frame_err  (w_rx_err)
    );

    always_comb begin
        w_map = UNMAPPED;
        case (w_byte)
            SC_Q: w_map = ASCII_Q;
            SC_W: w_map = ASCII_W;
            SC_E: w_map = ASCII_E;
            SC_R: w_map = ASCII_R;
            SC_T: w_map = ASCII_T;
            SC_Y: w_map = ASCII_Y;
            SC_U: w_map = ASCII_U;
            SC_I: w_map = ASCII_I;
            SC_O: w_map = ASCII_O;
            SC_P: w_map = ASCII_P;
            SC_A: w_map = ASCII_A;
            SC_S: w_map = ASCII_S;
            SC_D: w_map = ASCII_D;
            SC_F: w_map = ASCII_F;
            SC_G: w_map = ASCII_G;
            SC_H: w_map = ASCII_H;
            SC_J: w_map = ASCII_J;
            SC_K: w_map = ASCII_K;
            SC_L: w_map = ASCII_L;
            default: w_map = UNMAPPED;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ascii <= UNMAPPED;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ext   <= 1'b0;
            r_brk   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= w_rx_err;
            if (w_strobe) begin
                if (w_byte == SC_E0) begin
                    r_ext <= 1'b1;
                end else if (w_byte == SC_F0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    if (!r_ext && w_map != UNMAPPED) begin
                        if (r_brk) begin
                            if (w_map == r_ascii) begin
                                r_held <= 1'b0;
                            end
                        // A repeat of the held key is typematic and stays silent.
                        end else if (!(w_map == r_ascii && r_held)) begin
                            r_ascii <= w_map;
                            r_valid <= 1'b1;
                            r_held  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign ascii_val = r_ascii;
    assign key_valid = r_valid;
    assign key_held  = r_held;
    assign frame_err = r_ferr;

endmodule
